// File: rtl/step_clk_gen.sv
// rtl/step_clk_gen.sv - single-step / free-run clock-enable generator with debounce and step counter
module step_clk_gen #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int AUTO_DIV     = 50_000_000,
    parameter int CNT_W        = 16
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             oclk,
    input  logic             run_mode,
    output logic             step_en,
    output logic             rclk,
    output logic [CNT_W-1:0] step_cnt,
    output logic             btn_busy
);

    localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int VW = $clog2(AUTO_DIV);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [VW-1:0] DIV_LAST = VW'(AUTO_DIV - 1);
    localparam logic [VW-1:0] DIV_HALF = VW'(AUTO_DIV / 2);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DW-1:0]       cnt;
    logic [DW-1:0]       cnt_nxt;
    logic [VW-1:0]       div;
    logic [VW-1:0]       div_nxt;
    logic [SYNC_STAGES-1:0] oclk_sync;
    logic [SYNC_STAGES-1:0] mode_sync;
    logic                mode_q;
    logic                oclk_s;
    logic                mode_s;
    logic                mode_chg;
    logic                press_edge;

    assign oclk_s   = oclk_sync[SYNC_STAGES-1];
    assign mode_s   = mode_sync[SYNC_STAGES-1];
    assign mode_chg = mode_s ^ mode_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        press_edge = 1'b0;
        case (state)
            IDLE: begin
                if (oclk_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!oclk_s) begin
                    state_nxt = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nxt  = PRESSED;
                    press_edge = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!oclk_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A high sample here is release bounce: back to PRESSED without a pulse
                if (oclk_s) begin
                    state_nxt = PRESSED;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        div_nxt = '0;
        if (!mode_chg && mode_s) begin
            div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            oclk_sync <= '0;
            mode_sync <= '0;
            mode_q    <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            div       <= '0;
            step_en   <= 1'b0;
            rclk      <= 1'b0;
            step_cnt  <= '0;
            btn_busy  <= 1'b0;
        end else begin
            oclk_sync <= {oclk_sync[SYNC_STAGES-2:0], oclk};
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], run_mode};
            mode_q    <= mode_s;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div       <= div_nxt;
            btn_busy  <= (state_nxt != IDLE);
            if (mode_s) begin
                step_en <= !mode_chg && (div_nxt == DIV_LAST);
                rclk    <= (div_nxt < DIV_HALF);
            end else begin
                step_en <= !mode_chg && press_edge;
                rclk    <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
            end
            step_cnt <= step_cnt + CNT_W'(step_en);
        end
    end

endmodule

// File: tb/tb_step_clk_gen.sv
// tb/tb_step_clk_gen.sv - randomized scoreboard bench for step_clk_gen against a run-length reference model
module tb_step_clk_gen;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int DIV  = 8;
    localparam int CW   = 4;

    logic          clk;
    logic          rst;
    logic          oclk;
    logic          run_mode;
    logic          step_en;
    logic          rclk;
    logic [CW-1:0] step_cnt;
    logic          btn_busy;

    step_clk_gen #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_CYC(DEB),
        .AUTO_DIV    (DIV),
        .CNT_W       (CW)
    ) dut (
        .clk_100MHz(clk),
        .rst       (rst),
        .oclk      (oclk),
        .run_mode  (run_mode),
        .step_en   (step_en),
        .rclk      (rclk),
        .step_cnt  (step_cnt),
        .btn_busy  (btn_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          se;
        logic          rc;
        logic [CW-1:0] sc;
        logic          bb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the debounced level flips once DEB+1 consecutive synchronised
    // samples disagree with it; free-run phase is edges since the mode settled, mod DIV.
    logic oq[$];
    logic mq[$];
    logic d;
    int   run;
    int   n;
    logic m_prev;
    int   pulses;

    task automatic model_reset();
        oq.delete();
        mq.delete();
        for (int i = 0; i < SYNC; i++) begin
            oq.push_back(1'b0);
            mq.push_back(1'b0);
        end
        d      = 1'b0;
        run    = 0;
        n      = 0;
        m_prev = 1'b0;
        pulses = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        exp_t e;
        logic os, ms, chg, rose;
        if (rst) begin
            model_reset();
            e.se = 1'b0; e.rc = 1'b0; e.sc = '0; e.bb = 1'b0;
        end else begin
            os = oq.pop_front(); oq.push_back(oclk);
            ms = mq.pop_front(); mq.push_back(run_mode);
            chg    = (ms != m_prev);
            m_prev = ms;
            rose   = 1'b0;
            if (os != d) begin
                run++;
                if (run == DEB + 1) begin
                    d    = os;
                    run  = 0;
                    rose = os;
                end
            end else begin
                run = 0;
            end
            if (chg) n = 0;
            else if (ms) n++;
            e.se = chg ? 1'b0 : (ms ? ((n % DIV) == DIV - 1) : rose);
            e.rc = ms ? ((n % DIV) < DIV / 2) : d;
            e.sc = CW'(pulses);
            e.bb = d || (run > 0);
            pulses = (pulses + int'(e.se)) % (1 << CW);
        end
        q.push_back(e);
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow at %0t: got 0 entries expected 1", $time);
        end else begin
            e = q.pop_front();
            check("step_en",  int'(step_en),  int'(e.se));
            check("rclk",     int'(rclk),     int'(e.rc));
            check("step_cnt", int'(step_cnt), int'(e.sc));
            check("btn_busy", int'(btn_busy), int'(e.bb));
        end
    end

    task automatic drive(input logic o, input logic m, input logic r, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            oclk     = o;
            run_mode = m;
            rst      = r;
        end
    endtask

    initial begin
        rst      = 1'b1;
        oclk     = 1'b0;
        run_mode = 1'b0;
        drive(0, 0, 1, 3);
        drive(0, 0, 0, 4);
        // clean press
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 15);
        // bounce every 2 cycles
        for (int i = 0; i < 6; i++) drive(i[0] ? 1'b0 : 1'b1, 0, 0, 2);
        drive(0, 0, 0, 12);
        // release with a one-cycle glitch
        drive(1, 0, 0, 10);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 15);
        // free-run with concurrent presses
        for (int i = 0; i < 8; i++) drive(1'($urandom_range(0, 1)), 1, 0, 5);
        // long free-run for counter wrap, then a mid-period mode toggle
        drive(0, 1, 0, 140);
        drive(0, 0, 0, 3);
        drive(0, 1, 0, 21);
        drive(0, 0, 0, 6);
        // reset during PRESS_WAIT and mid free-run
        drive(1, 0, 0, 4);
        drive(0, 0, 1, 2);
        drive(0, 0, 0, 12);
        drive(0, 1, 0, 13);
        drive(0, 1, 1, 1);
        drive(0, 0, 0, 12);
        // randomized traffic
        for (int s = 0; s < 250; s++) begin
            logic o, m, r;
            o = 1'($urandom_range(0, 1));
            m = ($urandom_range(0, 7) == 0) ? ~run_mode : run_mode;
            r = ($urandom_range(0, 59) == 0);
            drive(o, m, r, r ? 1 : int'($urandom_range(1, 9)));
        end
        drive(0, 0, 0, 10);
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
